multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/mips_pkg.sv | 53 +++++
 rtl/aludecoder.sv | 29 ++
 rtl/multicycle_controller.sv | 162 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: state codes, opcode and
// funct constants, ALU control codes and the FSM-to-decoder aluop encoding.
// Optional feature macro: MIPS_ADDI_J_EN (adds the addi and j instruction states).
package mips_pkg;

   typedef enum logic [3:0] {
      StFetch   = 4'd0,
      StDecode  = 4'd1,
      StMemAdr  = 4'd2,
      StMemRd   = 4'd3,
      StMemWb   = 4'd4,
      StMemWr   = 4'd5,
      StExecute = 4'd6,
      StAluWb   = 4'd7,
      StBranch  = 4'd8
`ifdef MIPS_ADDI_J_EN
      ,
      StAddiEx  = 4'd9,
      StAddiWb  = 4'd10,
      StJump    = 4'd11
`endif
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // True for the R-type funct codes the ALU decoder implements.
   function automatic logic funct_legal(input logic [5:0] f);
      return (f == FUNCT_ADD) || (f == FUNCT_SUB) || (f == FUNCT_AND) ||
             (f == FUNCT_OR)  || (f == FUNCT_SLT);
   endfunction

endpackage

// File: rtl/aludecoder.sv
// ALU decoder: maps the FSM's aluop and the instruction funct field to alucontrol.
module aludecoder
   import mips_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   output logic [2:0] alucontrol
);

   // Fixed add/sub for address and branch math, funct-driven for R-type execute.
   always_comb begin
      alucontrol = ALU_ADD;
      case (aluop)
         ALUOP_SUB:   alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FUNCT_ADD: alucontrol = ALU_ADD;
               FUNCT_SUB: alucontrol = ALU_SUB;
               FUNCT_AND: alucontrol = ALU_AND;
               FUNCT_OR:  alucontrol = ALU_OR;
               FUNCT_SLT: alucontrol = ALU_SLT;
               default:   alucontrol = ALU_ADD;
            endcase
         end
         default:     alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM (Moore). Outputs decode from the state register;
// alucontrol also depends on funct, pcen on zero, and illegal on opcode/funct in
// DECODE. Optional feature macro: MIPS_ADDI_J_EN enables addi and j.
module multicycle_controller
   import mips_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic [2:0] alucontrol,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic       iord,
   output logic       regdst,
   output logic       memtoreg,
   output logic       pcen,
   output logic       irwrite,
   output logic       regwrite,
   output logic       memwrite,
   output logic       illegal,
   output logic [3:0] state
);

   state_e     state_q, state_d;
   logic       decode_legal;
   logic [1:0] aluop;
   logic       pcen_s, irwrite_s, regwrite_s, memwrite_s, illegal_s;

   // State register; reset lands in FETCH without waiting for a clock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= StFetch;
      else        state_q <= state_d;
   end

   // Opcode/funct legality as seen in DECODE.
   always_comb begin
      decode_legal = 1'b0;
      case (opcode)
         OP_LW, OP_SW, OP_BEQ: decode_legal = 1'b1;
         OP_RTYPE:             decode_legal = funct_legal(funct);
`ifdef MIPS_ADDI_J_EN
         OP_ADDI, OP_J:        decode_legal = 1'b1;
`else
         OP_ADDI, OP_J:        decode_legal = 1'b0;
`endif
         default:              decode_legal = 1'b0;
      endcase
   end

   // Next-state logic; unused codes and illegal decodes fall back to FETCH.
   always_comb begin
      state_d = StFetch;
      case (state_q)
         StFetch:   state_d = StDecode;
         StDecode: begin
            if (decode_legal) begin
               case (opcode)
                  OP_LW, OP_SW: state_d = StMemAdr;
                  OP_RTYPE:     state_d = StExecute;
                  OP_BEQ:       state_d = StBranch;
`ifdef MIPS_ADDI_J_EN
                  OP_ADDI:      state_d = StAddiEx;
                  OP_J:         state_d = StJump;
`endif
                  default:      state_d = StFetch;
               endcase
            end
         end
         StMemAdr:  state_d = (opcode == OP_SW) ? StMemWr : StMemRd;
         StMemRd:   state_d = StMemWb;
         StExecute: state_d = StAluWb;
`ifdef MIPS_ADDI_J_EN
         StAddiEx:  state_d = StAddiWb;
`endif
         default:   state_d = StFetch;
      endcase
   end

   // Per-state output decode; anything not set here stays at its idle value.
   always_comb begin
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      iord       = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      aluop      = ALUOP_ADD;
      pcen_s     = 1'b0;
      irwrite_s  = 1'b0;
      regwrite_s = 1'b0;
      memwrite_s = 1'b0;
      illegal_s  = 1'b0;
      case (state_q)
         StFetch: begin
            alusrcb   = 2'b01;
            irwrite_s = 1'b1;
            pcen_s    = 1'b1;
         end
         StDecode: begin
            alusrcb   = 2'b11;
            illegal_s = ~decode_legal;
         end
         StMemAdr: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         StMemRd:  iord = 1'b1;
         StMemWb: begin
            memtoreg   = 1'b1;
            regwrite_s = 1'b1;
         end
         StMemWr: begin
            iord       = 1'b1;
            memwrite_s = 1'b1;
         end
         StExecute: begin
            alusrca = 1'b1;
            aluop   = ALUOP_FUNCT;
         end
         StAluWb: begin
            regdst     = 1'b1;
            regwrite_s = 1'b1;
         end
         StBranch: begin
            alusrca = 1'b1;
            aluop   = ALUOP_SUB;
            pcsrc   = 2'b01;
            pcen_s  = zero;
         end
`ifdef MIPS_ADDI_J_EN
         StAddiEx: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         StAddiWb: regwrite_s = 1'b1;
         StJump: begin
            pcsrc  = 2'b10;
            pcen_s = 1'b1;
         end
`endif
         default:  illegal_s = 1'b1;
      endcase
   end

   aludecoder u_aludecoder (
      .aluop      (aluop),
      .funct      (funct),
      .alucontrol (alucontrol)
   );

   // Write enables and illegal are held low for the whole reset interval.
   assign pcen     = pcen_s & reset;
   assign irwrite  = irwrite_s & reset;
   assign regwrite = regwrite_s & reset;
   assign memwrite = memwrite_s & reset;
   assign illegal  = illegal_s & reset;
   assign state    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller; define MIPS_ADDI_J_EN to match the DUT build.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode, funct;
   logic       zero;
   logic [2:0] alucontrol;
   logic       alusrca, iord, regdst, memtoreg, pcen, irwrite, regwrite, memwrite, illegal;
   logic [1:0] alusrcb, pcsrc;
   logic [3:0] state;
   logic [15:0] outs;

   int n_vec = 0;
   int n_err = 0;

   // {alucontrol, alusrca, alusrcb, pcsrc, iord, regdst, memtoreg,
   //  pcen, irwrite, regwrite, memwrite, illegal}
   localparam logic [15:0] P_FETCH  = 16'b010_0_01_00_0_0_0_1_1_0_0_0;
   localparam logic [15:0] P_RST    = 16'b010_0_01_00_0_0_0_0_0_0_0_0;
   localparam logic [15:0] P_DEC    = 16'b010_0_11_00_0_0_0_0_0_0_0_0;
   localparam logic [15:0] P_DECILL = 16'b010_0_11_00_0_0_0_0_0_0_0_1;
   localparam logic [15:0] P_MEMADR = 16'b010_1_10_00_0_0_0_0_0_0_0_0;
   localparam logic [15:0] P_MEMRD  = 16'b010_0_00_00_1_0_0_0_0_0_0_0;
   localparam logic [15:0] P_MEMWB  = 16'b010_0_00_00_0_0_1_0_0_1_0_0;
   localparam logic [15:0] P_MEMWR  = 16'b010_0_00_00_1_0_0_0_0_0_1_0;
   localparam logic [15:0] P_EXSLT  = 16'b111_1_00_00_0_0_0_0_0_0_0_0;
   localparam logic [15:0] P_ALUWB  = 16'b010_0_00_00_0_1_0_0_0_1_0_0;
   localparam logic [15:0] P_BR1    = 16'b110_1_00_01_0_0_0_1_0_0_0_0;
   localparam logic [15:0] P_BR0    = 16'b110_1_00_01_0_0_0_0_0_0_0_0;
   localparam logic [15:0] P_JUMP   = 16'b010_0_00_10_0_0_0_1_0_0_0_0;
   localparam logic [15:0] P_ADDIWB = 16'b010_0_00_00_0_0_0_0_0_1_0_0;

   logic [5:0] ft [4] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101};
   logic [2:0] ac [4] = '{3'b010, 3'b110, 3'b000, 3'b001};

   multicycle_controller dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
      .alucontrol (alucontrol),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .pcsrc      (pcsrc),
      .iord       (iord),
      .regdst     (regdst),
      .memtoreg   (memtoreg),
      .pcen       (pcen),
      .irwrite    (irwrite),
      .regwrite   (regwrite),
      .memwrite   (memwrite),
      .illegal    (illegal),
      .state      (state)
   );

   always #5 clk = ~clk;

   assign outs = {alucontrol, alusrca, alusrcb, pcsrc, iord, regdst, memtoreg,
                  pcen, irwrite, regwrite, memwrite, illegal};

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %b required %b", tag, obs, exp);
      end
   endtask

   task automatic chk_st(input string tag, input logic [3:0] st, input logic [15:0] ov);
      chk({tag, ".state"}, {12'd0, state}, {12'd0, st});
      chk({tag, ".outs"}, outs, ov);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset  = 1'b1;
      opcode = 6'b0;
      funct  = 6'b0;
      zero   = 1'b0;
      #2 reset = 1'b0;             // asynchronous assert before any clock edge
      #2 chk_st("rst_async", 4'd0, P_RST);
      step();
      step();
      chk_st("rst_held", 4'd0, P_RST);
      @(negedge clk);
      reset = 1'b1;
      opcode = 6'b100011;          // lw
      #1 chk_st("lw_fetch", 4'd0, P_FETCH);
      step(); chk_st("lw_dec", 4'd1, P_DEC);
      step(); chk_st("lw_adr", 4'd2, P_MEMADR);
      step(); chk_st("lw_rd", 4'd3, P_MEMRD);
      step(); chk_st("lw_wb", 4'd4, P_MEMWB);
      step(); chk_st("lw_done", 4'd0, P_FETCH);

      opcode = 6'b000000;          // R-type slt
      funct  = 6'b101010;
      step(); chk_st("slt_dec", 4'd1, P_DEC);
      step(); chk_st("slt_ex", 4'd6, P_EXSLT);
      step(); chk_st("slt_wb", 4'd7, P_ALUWB);
      step(); chk_st("slt_done", 4'd0, P_FETCH);

      for (int i = 0; i < 4; i++) begin
         funct = ft[i];
         step();
         step(); chk_st($sformatf("rtype%0d_ex", i), 4'd6, {ac[i], 1'b1, 12'd0});
         step(); chk_st($sformatf("rtype%0d_wb", i), 4'd7, P_ALUWB);
         step();
      end

      opcode = 6'b101011;          // sw
      step(); chk_st("sw_dec", 4'd1, P_DEC);
      step(); chk_st("sw_adr", 4'd2, P_MEMADR);
      step(); chk_st("sw_wr", 4'd5, P_MEMWR);
      step(); chk_st("sw_done", 4'd0, P_FETCH);

      opcode = 6'b000100;          // beq taken
      zero   = 1'b1;
      step(); chk_st("beq1_dec", 4'd1, P_DEC);
      step(); chk_st("beq1_br", 4'd8, P_BR1);
      step(); chk_st("beq1_done", 4'd0, P_FETCH);
      zero = 1'b0;                 // beq not taken
      step();
      step(); chk_st("beq0_br", 4'd8, P_BR0);
      step(); chk_st("beq0_done", 4'd0, P_FETCH);

      opcode = 6'b111111;          // unsupported opcode
      step(); chk_st("badop_dec", 4'd1, P_DECILL);
      step(); chk_st("badop_next", 4'd0, P_FETCH);

      opcode = 6'b000000;          // unsupported funct
      funct  = 6'b000111;
      step(); chk_st("badfn_dec", 4'd1, P_DECILL);
      step(); chk_st("badfn_next", 4'd0, P_FETCH);

`ifdef MIPS_ADDI_J_EN
      opcode = 6'b000010;          // j
      step(); chk_st("j_dec", 4'd1, P_DEC);
      step(); chk_st("j_jump", 4'd11, P_JUMP);
      step(); chk_st("j_done", 4'd0, P_FETCH);
      opcode = 6'b001000;          // addi
      step(); chk_st("addi_dec", 4'd1, P_DEC);
      step(); chk_st("addi_ex", 4'd9, P_MEMADR);
      step(); chk_st("addi_wb", 4'd10, P_ADDIWB);
      step(); chk_st("addi_done", 4'd0, P_FETCH);
`else
      opcode = 6'b000010;          // j unsupported in this build
      step(); chk_st("j_dec", 4'd1, P_DECILL);
      step(); chk_st("j_next", 4'd0, P_FETCH);
      opcode = 6'b001000;          // addi unsupported in this build
      step(); chk_st("addi_dec", 4'd1, P_DECILL);
      step(); chk_st("addi_next", 4'd0, P_FETCH);
`endif

      opcode = 6'b101011;          // sw interrupted by reset in MEMWR
      step();
      step();
      step(); chk_st("rstmid_wr", 4'd5, P_MEMWR);
      #2 reset = 1'b0;
      #1 chk_st("rstmid_rst", 4'd0, P_RST);
      @(negedge clk);
      reset  = 1'b1;
      opcode = 6'b100011;
      #1 chk_st("rstmid_fetch", 4'd0, P_FETCH);
      step(); chk_st("rstmid_dec", 4'd1, P_DEC);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
